// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and parameter-legality checks for sync_fifo_param.
// Includes the count width calculation and range checks on the thresholds.
package sync_fifo_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit width_ok(input int w);
    return w >= 1;
  endfunction

  function automatic bit depth_ok(input int d);
    return (d >= 2) && ((d & (d - 1)) == 0);
  endfunction

  function automatic bit af_ok(input int t, input int d);
    return (t >= 1) && (t <= d);
  endfunction

  function automatic bit ae_ok(input int t, input int d);
    return (t >= 0) && (t <= d - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_mem.sv
// FIFO storage: one write port and a registered, resettable read port.
// The array itself is never reset.
module sync_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Same-edge read of the slot being written returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy, almost flags and rd strobe.
// Sticky overflow/underflow flags exist only when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic                     full_o,
  output logic                     almost_full_o,
  input  logic                     rd_en_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     rd_valid_o,
  output logic                     empty_o,
  output logic                     almost_empty_o,
  output logic [cnt_w(DEPTH)-1:0]  count_o,
  input  logic                     err_clr_i,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (!width_ok(DATA_W)) begin : g_bad_width
    $error("sync_fifo_param: DATA_W must be >= 1");
  end
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (!af_ok(AF_THRESH, DEPTH)) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
  end
  if (!ae_ok(AE_THRESH, DEPTH)) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_rd_valid;
  logic          w_full;
  logic          w_empty;
  logic          w_wr_acc;
  logic          w_rd_acc;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  // No bypass: a read on empty is refused even alongside a write.
  assign w_rd_acc = rd_en_i && !w_empty;
  assign w_wr_acc = wr_en_i && (!w_full || w_rd_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_i),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (data_o)
  );

  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign almost_full_o  = (r_count >= CW'(AF_THRESH));
  assign almost_empty_o = (r_count <= CW'(AE_THRESH));
  assign count_o        = r_count;
  assign rd_valid_o     = r_rd_valid;

`ifdef SYNC_FIFO_ERR_EN
  logic r_ovf;
  logic r_udf;

  // A new rejection outranks a clear arriving on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (wr_en_i && !w_wr_acc) r_ovf <= 1'b1;
      else if (err_clr_i)       r_ovf <= 1'b0;
      if (rd_en_i && !w_rd_acc) r_udf <= 1'b1;
      else if (err_clr_i)       r_udf <= 1'b0;
    end
  end

  assign overflow_o  = r_ovf;
  assign underflow_o = r_udf;
`else
  logic w_unused_clr;
  assign w_unused_clr = err_clr_i;
  assign overflow_o   = 1'b0;
  assign underflow_o  = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH=16, DATA_W=8).
// Directed steps plus random traffic checked against a queue-based model.
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AF = 14;
  localparam int AE = 2;
  localparam int CW = $clog2(DP) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en_i;
  logic [DW-1:0] data_i;
  logic          full_o;
  logic          almost_full_o;
  logic          rd_en_i;
  logic [DW-1:0] data_o;
  logic          rd_valid_o;
  logic          empty_o;
  logic          almost_empty_o;
  logic [CW-1:0] count_o;
  logic          err_clr_i;
  logic          overflow_o;
  logic          underflow_o;

  sync_fifo_param #(
    .DATA_W    (DW),
    .DEPTH     (DP),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en_i        (wr_en_i),
    .data_i         (data_i),
    .full_o         (full_o),
    .almost_full_o  (almost_full_o),
    .rd_en_i        (rd_en_i),
    .data_o         (data_o),
    .rd_valid_o     (rd_valid_o),
    .empty_o        (empty_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o),
    .err_clr_i      (err_clr_i),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ovf;
  logic          m_udf;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(count_o), 32'(n));
    chk({tag, ".full"}, 32'(full_o), 32'(n == DP));
    chk({tag, ".empty"}, 32'(empty_o), 32'(n == 0));
    chk({tag, ".afull"}, 32'(almost_full_o), 32'(n >= AF));
    chk({tag, ".aempty"}, 32'(almost_empty_o), 32'(n <= AE));
    chk({tag, ".rvalid"}, 32'(rd_valid_o), 32'(m_valid));
    chk({tag, ".data"}, 32'(data_o), 32'(m_data));
    chk({tag, ".ovf"}, 32'(overflow_o), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(underflow_o), 32'(m_udf));
  endtask

  task automatic step(input string tag, input logic wr, input logic [DW-1:0] d,
                      input logic rd, input logic clr);
    bit rd_ok;
    bit wr_ok;
    wr_en_i   = wr;
    data_i    = d;
    rd_en_i   = rd;
    err_clr_i = clr;
    rd_ok = rd && (q.size() > 0);
    wr_ok = wr && ((q.size() < DP) || rd_ok);
    @(posedge clk);
    #1;
    if (rd_ok) m_data = q.pop_front();
    if (wr_ok) q.push_back(d);
    m_valid = rd_ok;
`ifdef SYNC_FIFO_ERR_EN
    m_ovf = (wr && !wr_ok) || (m_ovf && !clr);
    m_udf = (rd && !rd_ok) || (m_udf && !clr);
`endif
    check_all(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_en_i   = 1'b0;
    rd_en_i   = 1'b0;
    data_i    = '0;
    err_clr_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) step("fill", 1'b1, DW'(8'h11 + i), 1'b0, 1'b0);
    step("fill16", 1'b1, 8'h20, 1'b0, 1'b0);
    step("ovf_wr", 1'b1, 8'hAA, 1'b0, 1'b0);
    step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);

    step("full_wr_rd", 1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_last", 32'(data_o), 32'h55);

    step("udf_rd_wr", 1'b1, 8'h3C, 1'b1, 1'b0);
    step("rd_3c", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("rd_3c_val", 32'(data_o), 32'h3C);
    step("udf_clr", 1'b0, 8'h00, 1'b0, 1'b1);

    step("stream0", 1'b1, 8'h80, 1'b0, 1'b0);
    for (int i = 1; i < 40; i++) begin
      step("stream", 1'b1, DW'(8'h80 + i), 1'b1, 1'b0);
      chk("stream_gap", 32'(rd_valid_o), 32'd1);
    end
    step("stream_end", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_last", 32'(data_o), 32'hA7);

    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), DW'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    while (q.size() > 0) step("pre_drain", 1'b0, 8'h00, 1'b1, 1'b1);
    step("pre_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step("fill7", 1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
    chk("fill7_cnt", 32'(count_o), 32'd7);
    wr_en_i = 1'b1;
    rd_en_i = 1'b1;
    data_i  = 8'h99;
    rst_n   = 1'b0;
    #2;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    rst_n   = 1'b1;
    step("post_wr", 1'b1, 8'h77, 1'b0, 1'b0);
    step("post_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_val", 32'(data_o), 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
